// File: rtl/seq_pkg.sv
// Shared types and constants for the program sequencer: FSM states, opcode prefixes,
// CU register-enable bit positions and data-bus source codes.
package seq_pkg;

  typedef enum logic [1:0] {
    RST  = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } seq_state_e;

  localparam logic [7:0] NOP_IR = 8'hC8;

  // Opcode prefixes; LOAD is any instruction with ir[7] clear.
  localparam logic [1:0] OP_MOVE_PFX = 2'b10;
  localparam logic [2:0] OP_ALU_PFX  = 3'b110;
  localparam logic [3:0] OP_JMP_PFX  = 4'b1110;
  localparam logic [3:0] OP_JNZ_PFX  = 4'b1111;

  localparam int RE_X0    = 0;
  localparam int RE_X1    = 1;
  localparam int RE_Y0    = 2;
  localparam int RE_Y1    = 3;
  localparam int RE_R     = 4;
  localparam int RE_M     = 5;
  localparam int RE_I     = 6;
  localparam int RE_DM    = 7;
  localparam int RE_O_REG = 8;

  localparam logic [3:0] SRC_X0    = 4'd0;
  localparam logic [3:0] SRC_X1    = 4'd1;
  localparam logic [3:0] SRC_Y0    = 4'd2;
  localparam logic [3:0] SRC_Y1    = 4'd3;
  localparam logic [3:0] SRC_R     = 4'd4;
  localparam logic [3:0] SRC_M     = 4'd5;
  localparam logic [3:0] SRC_I     = 4'd6;
  localparam logic [3:0] SRC_DM    = 4'd7;
  localparam logic [3:0] SRC_PM    = 4'd8;
  localparam logic [3:0] SRC_IPINS = 4'd9;

  // Destination field -> register enable; code 4 addresses o_reg rather than r.
  function automatic logic [8:0] dst_onehot(input logic [2:0] dst);
    logic [8:0] oh;
    oh = 9'd1 << dst;
    if (dst == 3'd4) oh = 9'd1 << RE_O_REG;
    return oh;
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational decode of the instruction register into CU controls plus the
// jump decision and jump target.
module instr_decoder
  import seq_pkg::*;
(
  input  logic [7:0] ir,
  input  logic       r_eq_0,
  output logic [3:0] source_sel,
  output logic [8:0] reg_en,
  output logic       i_sel,
  output logic       x_sel,
  output logic       y_sel,
  output logic       jump_taken,
  output logic [7:0] target
);

  logic [2:0] dst;
  logic [2:0] src;
  logic       i_inc;

  always_comb begin
    dst        = ir[5:3];
    src        = ir[2:0];
    source_sel = SRC_X0;
    reg_en     = '0;
    i_sel      = 1'b0;
    x_sel      = 1'b0;
    y_sel      = 1'b0;
    jump_taken = 1'b0;
    i_inc      = 1'b0;
    target     = {ir[3:0], 4'h0};

    if (ir[7] == 1'b0) begin
      dst        = ir[6:4];
      source_sel = SRC_PM;
      reg_en     = dst_onehot(dst);
      i_inc      = (dst == 3'd7);
    end else if (ir[7:6] == OP_MOVE_PFX) begin
      // A move onto itself is how the CU reads its input pins.
      source_sel = (src == dst) ? SRC_IPINS : {1'b0, src};
      reg_en     = dst_onehot(dst);
      i_inc      = ((dst == 3'd7) || ((src == 3'd7) && (src != dst))) && (dst != 3'd6);
    end else if (ir[7:5] == OP_ALU_PFX) begin
      x_sel      = ir[4];
      y_sel      = ir[3];
      reg_en[RE_R] = 1'b1;
    end else if (ir[7:4] == OP_JMP_PFX) begin
      jump_taken = 1'b1;
    end else begin
      jump_taken = ~r_eq_0;
    end

    // Any data-memory access through i post-increments i, unless i itself is written.
    if (i_inc) begin
      reg_en[RE_I] = 1'b1;
      i_sel        = 1'b1;
    end
  end

endmodule

// File: rtl/program_sequencer.sv
// Fetch/decode stage ahead of the 4-bit CU: owns pc, ir and the RST/RUN(/HALT) FSM.
// Define SEQ_HALT_EN to add the halt_req/halted handshake and the HALT state.
module program_sequencer #(
  parameter int              PC_W      = 8,
  parameter logic [PC_W-1:0] RESET_VEC = '0,
  parameter logic [7:0]      NOP_IR    = 8'hC8
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [7:0]      pm_data,
  input  logic            r_eq_0,
`ifdef SEQ_HALT_EN
  input  logic            halt_req,
  output logic            halted,
`endif
  output logic [PC_W-1:0] pm_addr,
  output logic [7:0]      ir,
  output logic            sync_reset,
  output logic            i_sel,
  output logic            x_sel,
  output logic            y_sel,
  output logic [3:0]      source_sel,
  output logic [3:0]      nibble_ir,
  output logic [8:0]      reg_en,
  output logic            NOPC8,
  output logic            NOPCF,
  output logic            NOPD8,
  output logic            NOPDF
);

  seq_pkg::seq_state_e state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [7:0]          ir_q, ir_d;
  logic                flush_q, flush_d;
  logic                hold_en;
  logic [8:0]          dec_reg_en;
  logic                jump_taken;
  logic [7:0]          target;

  instr_decoder u_decoder (
    .ir         (ir_q),
    .r_eq_0     (r_eq_0),
    .source_sel (source_sel),
    .reg_en     (dec_reg_en),
    .i_sel      (i_sel),
    .x_sel      (x_sel),
    .y_sel      (y_sel),
    .jump_taken (jump_taken),
    .target     (target)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= seq_pkg::RST;
      pc_q    <= RESET_VEC;
      ir_q    <= NOP_IR;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      flush_q <= flush_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    flush_d    = flush_q;
    sync_reset = 1'b0;
    hold_en    = 1'b0;

    case (state_q)
      seq_pkg::RST: begin
        sync_reset = 1'b1;
        hold_en    = 1'b1;
        state_d    = seq_pkg::RUN;
      end
      seq_pkg::RUN: begin
        // A taken jump discards the fetched word and injects one NOP bubble.
        if (jump_taken) begin
          pc_d    = PC_W'(target);
          ir_d    = NOP_IR;
          flush_d = 1'b1;
        end
`ifdef SEQ_HALT_EN
        else if (halt_req) begin
          state_d = seq_pkg::HALT;
        end
`endif
        else begin
          ir_d    = pm_data;
          pc_d    = pc_q + PC_W'(1);
          flush_d = 1'b0;
        end
      end
`ifdef SEQ_HALT_EN
      seq_pkg::HALT: begin
        hold_en = 1'b1;
        if (!halt_req) state_d = seq_pkg::RUN;
      end
`endif
      default: state_d = seq_pkg::RST;
    endcase
  end

  // The injected NOP (0xC8) decodes as an ALU op, so the bubble must mask its write.
  assign reg_en    = (hold_en || flush_q) ? 9'd0 : dec_reg_en;
  assign pm_addr   = pc_q;
  assign ir        = ir_q;
  assign nibble_ir = ir_q[3:0];
  assign NOPC8     = (ir_q == 8'hC8);
  assign NOPCF     = (ir_q == 8'hCF);
  assign NOPD8     = (ir_q == 8'hD8);
  assign NOPDF     = (ir_q == 8'hDF);

`ifdef SEQ_HALT_EN
  assign halted = (state_q == seq_pkg::HALT);
`endif

endmodule

// File: tb/tb_program_sequencer.sv
// Bench for program_sequencer: directed programs plus random programs, checked
// against an instruction-level reference model of fetch, decode and jumps.
`timescale 1ns/1ps
module tb_program_sequencer;

  localparam logic [7:0] NOP = 8'hC8;
`ifdef SEQ_HALT_EN
  localparam bit HAS_HALT = 1'b1;
`else
  localparam bit HAS_HALT = 1'b0;
`endif

  logic       clk;
  logic       reset_n;
  logic [7:0] pm_data;
  logic       r_eq_0;
  logic [7:0] pm_addr;
  logic [7:0] ir;
  logic       sync_reset, i_sel, x_sel, y_sel;
  logic [3:0] source_sel, nibble_ir;
  logic [8:0] reg_en;
  logic       NOPC8, NOPCF, NOPD8, NOPDF;
`ifdef SEQ_HALT_EN
  logic       halt_req;
  logic       halted;
`endif

  logic [7:0]  pm [256];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];

  // Reference model state: phase 0 = reset, 1 = running, 2 = halted.
  int         m_phase;
  logic [7:0] m_pc;
  logic [7:0] m_ir;
  logic       m_bubble;
  logic       m_first;

  program_sequencer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pm_data    (pm_data),
    .r_eq_0     (r_eq_0),
`ifdef SEQ_HALT_EN
    .halt_req   (halt_req),
    .halted     (halted),
`endif
    .pm_addr    (pm_addr),
    .ir         (ir),
    .sync_reset (sync_reset),
    .i_sel      (i_sel),
    .x_sel      (x_sel),
    .y_sel      (y_sel),
    .source_sel (source_sel),
    .nibble_ir  (nibble_ir),
    .reg_en     (reg_en),
    .NOPC8      (NOPC8),
    .NOPCF      (NOPCF),
    .NOPD8      (NOPD8),
    .NOPDF      (NOPDF)
  );

  assign pm_data = pm[pm_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void ref_decode(input logic [7:0] op, input logic z,
                                     output logic [3:0] ss, output logic [8:0] re,
                                     output logic is_, output logic xs, output logic ys,
                                     output logic jt, output logic [7:0] tg);
    int v, dst, src, slot;
    bit wr, inc;
    v = int'(op);
    ss = 4'd0; re = 9'd0; is_ = 1'b0; xs = 1'b0; ys = 1'b0; jt = 1'b0;
    wr = 1'b0; inc = 1'b0; dst = 0; src = 0;
    tg = 8'((v % 16) * 16);
    if (v < 128) begin
      dst = v / 16; ss = 4'd8; wr = 1'b1; inc = (dst == 7);
    end else if (v < 192) begin
      dst = (v / 8) % 8; src = v % 8;
      ss  = (src == dst) ? 4'd9 : 4'(src);
      wr  = 1'b1;
      inc = ((dst == 7) || (src == 7 && src != dst)) && (dst != 6);
    end else if (v < 224) begin
      xs = ((v / 16) % 2) == 1; ys = ((v / 8) % 2) == 1; re = 9'h010;
    end else if (v < 240) begin
      jt = 1'b1;
    end else begin
      jt = !z;
    end
    if (wr) begin
      slot = (dst == 4) ? 8 : dst;
      re   = 9'(1 << slot);
    end
    if (inc) begin
      re  = re | 9'h040;
      is_ = 1'b1;
    end
  endfunction

  task automatic model_reset();
    m_phase = 0; m_pc = 8'h00; m_ir = NOP; m_bubble = 1'b0; m_first = 1'b0;
  endtask

  task automatic model_step(input logic rn, input logic z, input logic h);
    logic [3:0] ss; logic [8:0] re; logic is_, xs, ys, jt; logic [7:0] tg;
    ref_decode(m_ir, z, ss, re, is_, xs, ys, jt, tg);
    if (!rn) begin
      model_reset();
    end else if (m_phase == 0) begin
      m_phase = 1; m_first = 1'b1;
    end else if (m_phase == 1) begin
      m_first = 1'b0;
      if (jt) begin
        m_pc = tg; m_ir = NOP; m_bubble = 1'b1;
      end else if (h && HAS_HALT) begin
        m_phase = 2;
      end else begin
        m_ir = pm[m_pc]; m_pc = m_pc + 8'd1; m_bubble = 1'b0;
      end
    end else if (!h) begin
      m_phase = 1;
    end
  endtask

  task automatic check_outputs();
    logic [3:0] ss; logic [8:0] re; logic is_, xs, ys, jt; logic [7:0] tg;
    ref_decode(m_ir, r_eq_0, ss, re, is_, xs, ys, jt, tg);
    check("pm_addr", 32'(pm_addr), 32'(m_pc));
    check("ir", 32'(ir), 32'(m_ir));
    check("sync_reset", 32'(sync_reset), 32'(m_phase == 0));
    // The first running cycle still holds the reset NOP; its write enable is left unchecked.
    if (!m_first)
      check("reg_en", 32'(reg_en), 32'((m_phase == 1 && !m_bubble) ? re : 9'd0));
    check("source_sel", 32'(source_sel), 32'(ss));
    check("i_sel", 32'(i_sel), 32'(is_));
    check("xy_sel", 32'({x_sel, y_sel}), 32'({xs, ys}));
    check("nibble_ir", 32'(nibble_ir), 32'(m_ir % 8'd16));
    check("nop_flags", 32'({NOPC8, NOPCF, NOPD8, NOPDF}),
          32'({m_ir == 8'hC8, m_ir == 8'hCF, m_ir == 8'hD8, m_ir == 8'hDF}));
`ifdef SEQ_HALT_EN
    check("halted", 32'(halted), 32'(m_phase == 2));
`endif
  endtask

  task automatic cycle(input logic z, input logic h);
    r_eq_0 = z;
`ifdef SEQ_HALT_EN
    halt_req = h;
`endif
    #1;
    check_outputs();
    model_step(reset_n, z, h);
    @(negedge clk);
  endtask

  task automatic fill_pm(input logic [7:0] v);
    for (int a = 0; a < 256; a++) pm[a] = v;
  endtask

  task automatic reset_seq();
    reset_n = 1'b0;
    model_reset();
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    reset_n = 1'b1;
  endtask

  initial begin
    logic hreq;
    reset_n = 1'b0;
    r_eq_0  = 1'b0;
`ifdef SEQ_HALT_EN
    halt_req = 1'b0;
`endif
    model_reset();
    fill_pm(8'h11);
    @(negedge clk);

    // Program A: LOAD/MOVE decode, JMP to 0x10, ALU + taken JNZ, then JMP at 0xFF.
    fill_pm(8'h11);
    pm[8'h00] = 8'h25; pm[8'h01] = 8'hA0; pm[8'h02] = 8'hBC; pm[8'h03] = 8'hA4;
    pm[8'h04] = 8'hE1; pm[8'h10] = 8'hC2; pm[8'h11] = 8'hF3; pm[8'h12] = 8'h25;
    pm[8'h30] = 8'hEF; pm[8'hFF] = 8'hE0;
    reset_seq();
    exp_q = {32'h00, 32'h00, 32'h01, 32'h02, 32'h03, 32'h04, 32'h05,
             32'h10, 32'h11, 32'h12, 32'h30, 32'h31, 32'hF0, 32'hF1};
    for (int c = 0; c < 30; c++) begin
      if (exp_q.size() > 0) check("pc_seq", 32'(pm_addr), exp_q.pop_front());
      if (c == 0) begin
        check("rel_sync_reset", 32'(sync_reset), 32'h1);
        check("rel_reg_en", 32'(reg_en), 32'h0);
      end
      if (c == 2) begin
        check("load_ss", 32'(source_sel), 32'h8);
        check("load_nib", 32'(nibble_ir), 32'h5);
        check("load_re", 32'(reg_en), 32'h004);
      end
      if (c == 3) check("mv_oreg_re", 32'(reg_en), 32'h100);
      if (c == 4) begin
        check("mv_dm_ss", 32'(source_sel), 32'h4);
        check("mv_dm_re", 32'(reg_en), 32'h0C0);
        check("mv_dm_isel", 32'(i_sel), 32'h1);
      end
      if (c == 5) begin
        check("mv_ipins_ss", 32'(source_sel), 32'h9);
        check("mv_ipins_re", 32'(reg_en), 32'h100);
      end
      if (c == 10) check("jnz_bubble_re", 32'(reg_en), 32'h0);
      if (c == 28) check("wrap_ir", 32'(ir), 32'hE0);
      if (c == 29) begin
        check("jmp_ff_pc", 32'(pm_addr), 32'h00);
        check("jmp_ff_nopc8", 32'(NOPC8), 32'h1);
        check("jmp_ff_re", 32'(reg_en), 32'h0);
      end
      cycle(1'b0, 1'b0);
    end

    // Program B: JNZ not taken, then a plain pc wrap 0xFF -> 0x00.
    fill_pm(8'h11);
    pm[8'h00] = 8'hE1; pm[8'h10] = 8'hC2; pm[8'h11] = 8'hF3; pm[8'h12] = 8'h25;
    reset_seq();
    for (int c = 0; c < 244; c++) begin
      if (c == 5) check("jnz_nt_pc", 32'(pm_addr), 32'h12);
      if (c == 6) begin
        check("jnz_nt_next", 32'(pm_addr), 32'h13);
        check("jnz_nt_re", 32'(reg_en), 32'h004);
      end
      if (c == 242) check("wrap_pre", 32'(pm_addr), 32'hFF);
      if (c == 243) begin
        check("wrap_post", 32'(pm_addr), 32'h00);
        check("wrap_re", 32'(reg_en), 32'h002);
      end
      cycle(1'b1, 1'b0);
    end

    // Reset asserted while a JMP sits in ir: the target must be dropped.
    fill_pm(8'h11);
    pm[8'h00] = 8'hE5;
    reset_seq();
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    check("midjmp_ir", 32'(ir), 32'hE5);
    reset_n = 1'b0;
    model_reset();
    #1;
    check("midjmp_rst_pc", 32'(pm_addr), 32'h00);
    check("midjmp_rst_ir", 32'(ir), 32'(NOP));
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    check("midjmp_hold_pc", 32'(pm_addr), 32'h00);
    reset_n = 1'b1;
    for (int c = 0; c < 4; c++) cycle(1'b0, 1'b0);

`ifdef SEQ_HALT_EN
    // Halt for three clocks at pc 0x05, then resume at the same pc.
    fill_pm(8'h11);
    reset_seq();
    for (int c = 0; c < 12; c++) begin
      if (c >= 7 && c <= 9) begin
        check("halt_pc", 32'(pm_addr), 32'h05);
        check("halt_flag", 32'(halted), 32'h1);
        check("halt_re", 32'(reg_en), 32'h0);
      end
      if (c == 10) check("resume_pc", 32'(pm_addr), 32'h05);
      if (c == 11) check("resume_next", 32'(pm_addr), 32'h06);
      cycle(1'b0, (c >= 6 && c <= 8));
    end
`endif

    // Random programs with random r_eq_0, occasional halts and reset pulses.
    for (int p = 0; p < 4; p++) begin
      for (int a = 0; a < 256; a++) pm[a] = 8'($urandom_range(0, 255));
      reset_seq();
      hreq = 1'b0;
      for (int c = 0; c < 800; c++) begin
        if (!reset_n && $urandom_range(0, 1) == 1) begin
          reset_n = 1'b1;
        end else if ($urandom_range(0, 299) == 0) begin
          reset_n = 1'b0;
          model_reset();
        end
        if ($urandom_range(0, 19) == 0) hreq = ~hreq;
        cycle(1'($urandom_range(0, 1)), hreq);
      end
      reset_n = 1'b1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
